// File: rtl/ram_block_copier_if.sv
// Single-port word RAM bus driven by the block copier.
// The master drives address, write data and write enable; the slave returns combinational read data.
interface ram_block_copier_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in;
    logic              mem_load;
    logic [DATA_W-1:0] mem_out;

    modport master (
        output mem_address,
        output mem_in,
        output mem_load,
        input  mem_out
    );

    modport slave (
        input  mem_address,
        input  mem_in,
        input  mem_load,
        output mem_out
    );
endinterface

// File: rtl/ram_block_copier.sv
// Block copy / fill engine for a single-port word RAM.
// Copy takes two cycles per word (read, then write); fill writes one word per cycle.
module ram_block_copier #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    ram_block_copier_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FILL,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W-1:0] r_count;
    logic              r_mode;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_load;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_src_nxt;
    logic [ADDR_W-1:0] w_dst_nxt;
    logic              w_last;

    assign w_src_nxt = r_src_ptr + ADDR_W'(1);
    assign w_dst_nxt = r_dst_ptr + ADDR_W'(1);
    assign w_last    = (r_count == ADDR_W'(1));

    // r_data doubles as the write-data register: read word in copy mode, constant in fill mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_count   <= '0;
            r_mode    <= 1'b0;
            r_data    <= '0;
            r_addr    <= '0;
            r_load    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_src_ptr <= src;
                            r_dst_ptr <= dst;
                            r_count   <= len;
                            r_mode    <= mode;
                            r_busy    <= 1'b1;
                            if (mode) begin
                                r_state <= S_FILL;
                                r_addr  <= dst;
                                r_data  <= fill_value;
                                r_load  <= 1'b1;
                            end else begin
                                r_state <= S_READ;
                                r_addr  <= src;
                            end
                        end
                    end
                end
                S_READ: begin
                    r_data  <= mem.mem_out;
                    r_addr  <= r_dst_ptr;
                    r_load  <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE, S_FILL: begin
                    r_dst_ptr <= w_dst_nxt;
                    r_count   <= r_count - ADDR_W'(1);
                    if (!r_mode)
                        r_src_ptr <= w_src_nxt;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_addr  <= w_dst_nxt;
                        r_load  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_mode) begin
                        r_state <= S_FILL;
                        r_addr  <= w_dst_nxt;
                    end else begin
                        r_state <= S_READ;
                        r_addr  <= w_src_nxt;
                        r_load  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write enable is gated by reset so no RAM write lands on a reset edge.
    assign mem.mem_load    = r_load & ~reset;
    assign mem.mem_address = r_addr;
    assign mem.mem_in      = r_data;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_ram_block_copier.sv
// Bench for ram_block_copier: bench-owned RAM, cycle-level transfer model, randomized transfers.
module tb_ram_block_copier;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode  = 1'b0;
    logic [13:0] src   = '0;
    logic [13:0] dst   = '0;
    logic [13:0] len   = '0;
    logic [15:0] fill_value = '0;
    logic        busy;
    logic        done;

    ram_block_copier_if #(.ADDR_W(14), .DATA_W(16)) mem_if ();

    ram_block_copier #(.ADDR_W(14), .DATA_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .mem        (mem_if)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int n_done = 0;

    logic [15:0] ram    [0:16383] = '{default: '0};
    logic [15:0] shadow [0:16383] = '{default: '0};
    logic [15:0] scratch[0:16383];

    logic        poke_en = 1'b0;
    logic [13:0] poke_a  = '0;
    logic [15:0] poke_d  = '0;

    assign mem_if.mem_out = ram[mem_if.mem_address];

    always @(posedge clock) begin
        if (mem_if.mem_load) begin
            ram[mem_if.mem_address] <= mem_if.mem_in;
            wr_cnt <= wr_cnt + 1;
        end else if (poke_en) begin
            ram[poke_a] <= poke_d;
        end
    end

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        load;
        logic [13:0] addr;
        logic [15:0] din;
    } rec_t;

    rec_t        q[$];
    logic [13:0] m_dst = '0;
    logic [15:0] m_din = '0;

    // Expected bus activity for a transfer accepted at the coming edge, one record per cycle.
    task automatic gen_transfer();
        logic [13:0] s, d;
        logic [15:0] v;
        s = src;
        d = dst;
        if (len == 14'd0) begin
            q.push_back({3'b010, m_dst, m_din});
        end else if (mode) begin
            for (int unsigned i = 0; i < len; i++) begin
                q.push_back({3'b101, d, fill_value});
                d = d + 14'd1;
            end
            m_din = fill_value;
            m_dst = d;
            q.push_back({3'b010, m_dst, m_din});
        end else begin
            scratch = shadow;
            for (int unsigned i = 0; i < len; i++) begin
                q.push_back({3'b100, s, m_din});
                v = scratch[s];
                scratch[d] = v;
                q.push_back({3'b101, d, v});
                m_din = v;
                s = s + 14'd1;
                d = d + 14'd1;
            end
            m_dst = d;
            q.push_back({3'b010, m_dst, m_din});
        end
    endtask

    always @(negedge clock) begin
        rec_t exp_r, act_r;
        bit   popped;
        act_r = {busy, done, mem_if.mem_load, mem_if.mem_address, mem_if.mem_in};
        if (poke_en)
            shadow[poke_a] = poke_d;
        if (reset) begin
            n_cmp++;
            if (mem_if.mem_load !== 1'b0) begin
                n_err++;
                $display("FAIL reset_load t=%0t: mem_load=%b, required 0", $time, mem_if.mem_load);
            end
            q.delete();
            m_dst = '0;
            m_din = '0;
        end else begin
            popped = (q.size() != 0);
            exp_r  = popped ? q.pop_front() : {3'b000, m_dst, m_din};
            n_cmp++;
            if (act_r !== exp_r) begin
                n_err++;
                $display("FAIL bus t=%0t: busy=%b done=%b load=%b addr=%h in=%h, required busy=%b done=%b load=%b addr=%h in=%h",
                         $time, act_r.busy, act_r.done, act_r.load, act_r.addr, act_r.din,
                         exp_r.busy, exp_r.done, exp_r.load, exp_r.addr, exp_r.din);
            end
            if (popped && exp_r.load)
                shadow[exp_r.addr] = exp_r.din;
            if (done)
                n_done++;
            if (!popped && start)
                gen_transfer();
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic poke(input logic [13:0] a, input logic [15:0] d);
        @(posedge clock);
        #1;
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        @(posedge clock);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic issue(input logic m, input logic [13:0] s, input logic [13:0] d,
                         input logic [13:0] l, input logic [15:0] f);
        @(posedge clock);
        #1;
        start = 1'b1;
        mode  = m;
        src   = s;
        dst   = d;
        len   = l;
        fill_value = f;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done; optionally pulses a stray start.
    task automatic measure(input int inject, output int done_at, output int busy_n);
        done_at = 0;
        busy_n  = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            #1;
            if (busy) busy_n++;
            if (i == inject) begin
                start = 1'b1;
                mode  = 1'b0;
                dst   = 14'd500;
                len   = 14'd3;
            end
            if (i == inject + 1) start = 1'b0;
            if (done) begin
                done_at = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            #1;
            if (q.size() == 0 && !start) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL idle_timeout: busy=%b, required transfer to finish within 300 cycles", busy);
        end
    endtask

    initial begin
        int          dn, bn, w0, d0, bad;
        logic [15:0] v30, v31;
        logic [13:0] rs, rl;

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_busy", int'(busy), 0);
        chk("reset_addr", int'(mem_if.mem_address), 0);

        poke(14'd100, 16'h1111);
        poke(14'd101, 16'h2222);
        poke(14'd102, 16'h3333);
        w0 = wr_cnt;
        issue(1'b0, 14'd100, 14'd200, 14'd3, 16'h0);
        measure(2, dn, bn);
        chk("copy_done_cycle", dn, 7);
        chk("copy_busy_cycles", bn, 6);
        wait_idle();
        chk("copy_writes", wr_cnt - w0, 3);
        chk("copy_ram200", int'(ram[200]), 16'h1111);
        chk("copy_ram201", int'(ram[201]), 16'h2222);
        chk("copy_ram202", int'(ram[202]), 16'h3333);
        chk("ignored_start_ram500", int'(ram[500]), 0);

        poke(14'd2, 16'h1234);
        issue(1'b1, 14'd0, 14'h3FFC, 14'd6, 16'hBEEF);
        measure(0, dn, bn);
        chk("fill_done_cycle", dn, 7);
        chk("fill_busy_cycles", bn, 6);
        wait_idle();
        chk("fill_3ffc", int'(ram[14'h3FFC]), 16'hBEEF);
        chk("fill_3fff", int'(ram[14'h3FFF]), 16'hBEEF);
        chk("fill_0000", int'(ram[0]), 16'hBEEF);
        chk("fill_0001", int'(ram[1]), 16'hBEEF);
        chk("fill_0002_kept", int'(ram[2]), 16'h1234);

        w0 = wr_cnt;
        issue(1'b0, 14'd5, 14'd777, 14'd0, 16'h0);
        measure(0, dn, bn);
        chk("len0_done_cycle", dn, 1);
        chk("len0_busy_cycles", bn, 0);
        wait_idle();
        chk("len0_writes", wr_cnt - w0, 0);

        poke(14'd10, 16'd5);
        poke(14'd11, 16'hAAAA);
        issue(1'b0, 14'd10, 14'd11, 14'd3, 16'h0);
        wait_idle();
        chk("overlap_11", int'(ram[11]), 5);
        chk("overlap_12", int'(ram[12]), 5);
        chk("overlap_13", int'(ram[13]), 5);

        v30 = 16'(($urandom_range(1, 16'hFFFF)));
        v31 = 16'(($urandom_range(1, 16'hFFFF)));
        poke(14'd30, v30);
        poke(14'd31, v31);
        poke(14'd32, 16'h5A5A);
        poke(14'd33, 16'hA5A5);
        w0 = wr_cnt;
        d0 = n_done;
        issue(1'b0, 14'd30, 14'd300, 14'd4, 16'h0);
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        chk("rst_writes", wr_cnt - w0, 2);
        chk("rst_no_done", n_done - d0, 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ram300", int'(ram[300]), int'(v30));
        chk("rst_ram301", int'(ram[301]), int'(v31));
        chk("rst_ram302", int'(ram[302]), 0);

        for (int unsigned a = 40; a < 72; a++)
            poke(14'(a), 16'($urandom));
        for (int k = 0; k < 40; k++) begin
            rs = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(36, 72));
            rl = 14'($urandom_range(0, 12));
            issue(1'($urandom_range(0, 1)), rs, 14'($urandom), rl, 16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 4)) @(posedge clock);
                issue(1'($urandom_range(0, 1)), 14'($urandom_range(36, 72)), 14'($urandom),
                      14'($urandom_range(0, 6)), 16'($urandom));
            end
            wait_idle();
        end

        repeat (3) @(negedge clock);
        bad = 0;
        for (int a = 0; a < 16384; a++)
            if (ram[a] !== shadow[a]) bad++;
        chk("final_ram_vs_model", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_block_copier.md
Name: ram_block_copier

Overview:
- Bus-initiator engine that drives the single-port word RAM interface (in, load, address, out) from the master side.
- Reads a source region and writes it to a destination region (copy mode), or writes a constant to a destination region (fill mode).
- Sits between the CPU/control logic and a RAM8K/RAM16K-style memory. Used for boot-time program/data loading and for screen/buffer clears without CPU involvement.

Parameters:
- ADDR_W, 14, width of every address, pointer and length field; memory depth 2^ADDR_W
- DATA_W, 16, memory word width

Ports:
- clock  input  1  system clock; all state updates on posedge
- reset  input  1  reset; synchronous, active-high
- start  input  1  request pulse; sampled only in IDLE
- mode  input  1  0 = copy, 1 = fill; latched on accepted start
- src  input  ADDR_W  first source address (copy only); latched on start
- dst  input  ADDR_W  first destination address; latched on start
- len  input  ADDR_W  word count; 0 = no-op
- fill_value  input  DATA_W  constant written in fill mode; latched on start
- busy  output  1  high while a transfer is in progress
- done  output  1  one-cycle completion pulse
- mem_address  output  ADDR_W  address to RAM
- mem_in  output  DATA_W  write data to RAM
- mem_load  output  1  write enable to RAM
- mem_out  input  DATA_W  RAM combinational read data for mem_address

Behaviour:
- States: IDLE, READ, WRITE, FILL, DONE. Registers: src_ptr, dst_ptr, count, data_reg, mode_reg, fill_reg.
- Reset (state register sampled high at posedge):
  - state=IDLE, busy=0, done=0, mem_load=0, mem_address=0, mem_in=0, all pointers/counters/data regs 0.
  - mem_load = (state-decoded load) AND NOT reset, so no RAM write occurs on any edge where reset is high, including reset mid-transfer.
- IDLE:
  - start=1, len!=0: latch inputs. Next state READ (mode 0) or FILL (mode 1).
  - start=1, len=0: next state DONE; no memory write.
  - start=0: stay in IDLE.
- READ: mem_address=src_ptr, mem_load=0. At posedge, data_reg<=mem_out; next state WRITE.
- WRITE: mem_address=dst_ptr, mem_in=data_reg, mem_load=1. At posedge:
  - src_ptr+1, dst_ptr+1, count-1.
  - Next state DONE if count==1, else READ.
- FILL: mem_address=dst_ptr, mem_in=fill_reg, mem_load=1. At posedge:
  - dst_ptr+1, count-1.
  - Next state DONE if count==1, else FILL.
- DONE: done=1, busy=0, mem_load=0. Next state IDLE unconditionally; start is ignored in DONE.
- busy=1 exactly in READ, WRITE and FILL. start while busy is ignored and no inputs are re-latched.
- Latency (start accepted at edge k):
  - Copy N words: busy for cycles k+1..k+2N; done high in cycle k+2N+1; 2 cycles per word.
  - Fill N words: busy for k+1..k+N; done in k+N+1.
  - len=0: done in k+1, busy never asserts.
- Pointer arithmetic is modulo 2^ADDR_W; addresses wrap from 2^ADDR_W-1 to 0 silently.
- Transfers always run in ascending address order.
  - Overlapping regions with dst>src propagate already-written data; this is defined behaviour, not an error.
- Outputs mem_address/mem_in/mem_load/busy/done are decoded from registered state only. Apart from the reset gating of mem_load, there is no combinational path from start, mem_out or other inputs to any output.
- In IDLE and DONE, mem_address holds dst_ptr and mem_in holds its last value. Neither is a don't-care, so a bench can compare exactly.
- Max transfer 2^ADDR_W-1 words.

Test Plan:
- Reset held 2 cycles, then released with start=0 -> busy=0, done=0, mem_load=0, mem_address=0 every cycle.
- Copy: preload RAM[100..102]=0x1111,0x2222,0x3333; start src=100, dst=200, len=3, mode=0 -> writes only at 200,201,202 with those values in order. busy high 6 cycles, done pulses in cycle 7 after the start edge.
- Fill wrap: dst=0x3FFC, len=6, fill_value=0xBEEF, mode=1 -> 0xBEEF written at 0x3FFC,0x3FFD,0x3FFE,0x3FFF,0x0000,0x0001. done 7 cycles after start; RAM[0x0002] unchanged.
- len=0 with start -> done pulses the next cycle, busy stays 0, mem_load never asserts.
- Start while busy: second start (dst=500) issued mid-copy of test 2 -> ignored; only addresses 200..202 written. Overlap: RAM[10]=5, src=10, dst=11, len=3 -> RAM[11..13]=5,5,5.
- Reset mid-copy: assert reset in the READ cycle after the 2nd WRITE of a len=4 copy -> exactly 2 destination words written, mem_load=0 during the reset cycle, done never pulses, then IDLE.
